mac_seq: RTL and testbench
==========================

MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 8: operand width, unsigned.
REQ-002 SHALL have parameter OUT_WIDTH, default 20: accumulator/result width.
REQ-003 SHALL have parameter LEN_WIDTH, default 8: dot-product length field width.
REQ-004 SHALL have port CLK  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-low reset, sampled on the rising edge of CLK.
REQ-006 SHALL have ports start in 1 (job request pulse) and len in LEN_WIDTH (operand-pair count, sampled with start).
REQ-007 SHALL have port busy  out  1  high in every state except IDLE.
REQ-008 SHALL have ports a_valid in 1, a_ready out 1, a_data in IN_WIDTH, b_data in IN_WIDTH: paired operand stream; transfer when a_valid & a_ready.
REQ-009 SHALL have ports mac_clr out 1 (active-high accumulator clear), mac_en out 1, mac_in_1 out IN_WIDTH, mac_in_2 out IN_WIDTH, mac_acc in OUT_WIDTH (registered accumulator value).
REQ-010 SHALL have ports res_valid out 1, res_ready in 1, res_data out OUT_WIDTH: result stream; transfer when res_valid & res_ready.

Function
REQ-011 SHALL implement FSM states IDLE, CLEAR, RUN, DRAIN, DONE.
REQ-012 IDLE: start=1 SHALL latch len into remaining-count and go to CLEAR; start SHALL be ignored in all other states.
REQ-013 CLEAR: mac_clr=1 for exactly one cycle; next RUN if remaining-count>0, else DRAIN.
REQ-014 RUN: a_ready=1; a_ready SHALL be 0 in every other state.
REQ-015 RUN: mac_en = a_valid & a_ready, combinational; mac_in_1=a_data, mac_in_2=b_data same cycle; both SHALL be 0 outside RUN.
REQ-016 Each RUN handshake SHALL decrement remaining-count; handshake with remaining-count=1 SHALL move to DRAIN; a_valid=0 SHALL hold state and count.
REQ-017 DRAIN: one cycle; res_data SHALL capture mac_acc at the end of it; next DONE.
REQ-018 DONE: res_valid=1; res_data SHALL hold stable until res_valid & res_ready, then go to IDLE the next cycle.
REQ-019 Latency with len=N>0, a_valid continuously high and res_ready high: start sampled in cycle 0, res_valid=1 in cycle N+3.
REQ-020 len=0 SHALL still clear and produce res_data=0 (mac_acc after clear) in cycle 3.
REQ-021 start in the same cycle as the DONE result handshake SHALL be ignored; a new job SHALL only be accepted in IDLE.
REQ-022 res_data width SHALL equal OUT_WIDTH; no truncation, sign extension or saturation is applied to mac_acc.

Reset
REQ-023 rst=0 at a rising edge SHALL force IDLE from any state, including mid-RUN, aborting the job with no result.
REQ-024 After reset: busy=0, a_ready=0, mac_en=0, mac_clr=0, mac_in_1=0, mac_in_2=0, res_valid=0, res_data=0, remaining-count=0.
REQ-025 rst SHALL take priority over start, abort and all handshakes in the same cycle.

Configuration
REQ-026 Macro MAC_SEQ_ABORT_EN defined: SHALL add port abort in 1; abort=1 in CLEAR, RUN or DRAIN SHALL go to IDLE next cycle, forcing a_ready=0 and mac_en=0 that cycle, with no res_valid; abort SHALL be ignored in IDLE and DONE.
REQ-027 Macro MAC_SEQ_ABORT_EN undefined: SHALL have no abort port; a job runs to completion or reset.

Verification
REQ-028 len=4, a=(1,2,3,4), b=(5,6,7,8), a_valid held high, behavioural MAC model -> res_data=70, res_valid in cycle 7, exactly 4 mac_en pulses.
REQ-029 len=3, a=(255,255,1), b=(255,1,1), a_valid low 2 cycles between pairs -> res_data=65281; mac_en only on handshake cycles; count held during gaps.
REQ-030 len=2 job done, res_ready low 5 cycles, start pulsed meanwhile -> res_valid/res_data stable, busy=1, start ignored; IDLE one cycle after res_ready=1.
REQ-031 len=0 -> one mac_clr pulse, a_ready never 1, res_data=0 with res_valid in cycle 3.
REQ-032 rst=0 after 2 of 4 pairs in RUN -> all outputs at reset values next cycle; then len=1, a=3, b=3 -> res_data=9.
REQ-033 MAC_SEQ_ABORT_EN defined, abort=1 after 1 of 3 pairs -> IDLE next cycle, no res_valid; next job len=1, a=2, b=5 -> res_data=10.

Source files
------------

// File: rtl/mac_seq.sv
// Sequencer for an external multiply-accumulate unit: clears the accumulator, streams len operand pairs, returns the sum.
// Optional macro MAC_SEQ_ABORT_EN adds an abort input that cancels a job in CLEAR, RUN or DRAIN.
module mac_seq #(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH = 20,
    parameter int unsigned LEN_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 rst,
`ifdef MAC_SEQ_ABORT_EN
    input  logic                 abort,
`endif
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [IN_WIDTH-1:0]  a_data,
    input  logic [IN_WIDTH-1:0]  b_data,
    output logic                 mac_clr,
    output logic                 mac_en,
    output logic [IN_WIDTH-1:0]  mac_in_1,
    output logic [IN_WIDTH-1:0]  mac_in_2,
    input  logic [OUT_WIDTH-1:0] mac_acc,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [OUT_WIDTH-1:0] res_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0]   res_q, res_d;
    logic                   abort_w;

`ifdef MAC_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    // State, remaining-count and result registers
    always_ff @(posedge CLK) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    // Next-state and MAC-side controls
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        a_ready  = 1'b0;
        mac_en   = 1'b0;
        mac_clr  = 1'b0;
        mac_in_1 = '0;
        mac_in_2 = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_d   = len;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                mac_clr = 1'b1;
                state_d = (cnt_q != '0) ? RUN : DRAIN;
            end
            RUN: begin
                a_ready  = 1'b1;
                mac_en   = a_valid;
                mac_in_1 = a_data;
                mac_in_2 = b_data;
                if (a_valid) begin
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Accumulator already holds the last product here
                res_d   = mac_acc;
                state_d = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort_w && (state_q == CLEAR || state_q == RUN || state_q == DRAIN)) begin
            state_d = IDLE;
            cnt_d   = '0;
            res_d   = res_q;
            a_ready = 1'b0;
            mac_en  = 1'b0;
        end
    end

    assign busy      = (state_q != IDLE);
    assign res_valid = (state_q == DONE);
    assign res_data  = res_q;

endmodule

// File: tb/tb_mac_seq.sv
// Self-checking bench for mac_seq: spec vector table, randomized jobs vs a dot-product model, reset/backpressure corners.
module tb_mac_seq;

    localparam int unsigned IN_W  = 8;
    localparam int unsigned OUT_W = 20;
    localparam int unsigned LEN_W = 8;

    typedef logic [IN_W-1:0] arr_t [8];

    typedef struct {
        int               n;
        arr_t             a;
        arr_t             b;
        int               gap;
        logic [OUT_W-1:0] exp_res;
        int               exp_cyc;
    } vec_t;

    logic             CLK = 1'b0;
    logic             rst;
    logic             abort;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             a_valid;
    logic             a_ready;
    logic [IN_W-1:0]  a_data;
    logic [IN_W-1:0]  b_data;
    logic             mac_clr;
    logic             mac_en;
    logic [IN_W-1:0]  mac_in_1;
    logic [IN_W-1:0]  mac_in_2;
    logic [OUT_W-1:0] mac_acc;
    logic             res_valid;
    logic             res_ready;
    logic [OUT_W-1:0] res_data;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mac_seq #(.IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W), .LEN_WIDTH(LEN_W)) dut (
        .CLK(CLK), .rst(rst),
`ifdef MAC_SEQ_ABORT_EN
        .abort(abort),
`endif
        .start(start), .len(len), .busy(busy),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .b_data(b_data),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_in_1(mac_in_1), .mac_in_2(mac_in_2),
        .mac_acc(mac_acc),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    // Behavioural accumulator the sequencer drives
    always_ff @(posedge CLK) begin
        if (mac_clr) mac_acc <= '0;
        else if (mac_en) mac_acc <= mac_acc + OUT_W'(mac_in_1) * OUT_W'(mac_in_2);
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] dot(input int n, input arr_t av, input arr_t bv);
        logic [OUT_W-1:0] s = '0;
        for (int i = 0; i < n; i++) s = s + OUT_W'(av[i]) * OUT_W'(bv[i]);
        return s;
    endfunction

    function automatic int lat(input int n, input int gap);
        return (n == 0) ? 3 : n + 3 + (n - 1) * gap;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; start = 1'b0; a_valid = 1'b0; abort = 1'b0; res_ready = 1'b1;
        tick();
        rst = 1'b1;
    endtask

    // Runs one job from IDLE; enters and leaves at posedge+1
    task automatic run_job(input int n, input arr_t av, input arr_t bv, input int gap,
                           input int hold, input bit poke,
                           output logic [OUT_W-1:0] res, output int vcyc,
                           output int ens, output int clrs, output int bad);
        int idx = 0;
        int wt = 0;
        int cyc = 0;
        int held = 0;
        logic [OUT_W-1:0] first = '0;
        ens = 0; clrs = 0; bad = 0; vcyc = -1; res = '0;
        start = 1'b1; len = LEN_W'(n); a_valid = 1'b0; res_ready = 1'b1;
        #1;
        if (busy) bad++;
        tick();
        start = 1'b0; cyc = 1;
        while (cyc < 300) begin
            if (res_valid) begin
                if (vcyc < 0) begin vcyc = cyc; first = res_data; end
                else if (res_data != first) bad++;
                if (!busy) bad++;
                res_ready = (held >= hold);
                start = poke;
                a_valid = 1'b0;
                #1;
                if (a_ready || mac_en || mac_clr) bad++;
                if (res_ready) begin
                    res = first;
                    tick();
                    start = 1'b0;
                    break;
                end
                held++;
            end else begin
                a_valid = (idx < n) && (wt == 0);
                a_data = av[idx % 8];
                b_data = bv[idx % 8];
                res_ready = 1'b1;
                start = 1'b0;
                #1;
                if (!busy) bad++;
                if (mac_clr) clrs++;
                if (mac_en) begin
                    ens++;
                    if (!a_valid || mac_in_1 != a_data || mac_in_2 != b_data) bad++;
                end
                if (a_ready && idx >= n) bad++;
                if (!a_ready && (mac_in_1 != '0 || mac_in_2 != '0 || mac_en)) bad++;
                if (a_valid && a_ready) begin idx++; wt = gap; end
                else if (!a_valid && wt > 0) wt--;
            end
            tick();
            cyc++;
        end
        a_valid = 1'b0;
    endtask

    task automatic job_check(input string nm, input int n, input arr_t av, input arr_t bv,
                             input int gap, input int hold, input bit poke,
                             input logic [OUT_W-1:0] exp_res, input int exp_cyc);
        logic [OUT_W-1:0] res;
        int vcyc, ens, clrs, bad;
        run_job(n, av, bv, gap, hold, poke, res, vcyc, ens, clrs, bad);
        chk({nm, " res_data"}, res, exp_res);
        chk({nm, " valid_cycle"}, vcyc, exp_cyc);
        chk({nm, " mac_en_count"}, ens, n);
        chk({nm, " mac_clr_count"}, clrs, 1);
        chk({nm, " protocol_errors"}, bad, 0);
        chk({nm, " idle_after"}, {busy, res_valid}, 0);
        if (vcyc < 0) do_reset();
    endtask

    initial begin
        vec_t tbl [5];
        arr_t ra, rb;
        int rn, rg;

        tbl[0].n = 4; tbl[0].a = '{1, 2, 3, 4, 0, 0, 0, 0}; tbl[0].b = '{5, 6, 7, 8, 0, 0, 0, 0};
        tbl[0].gap = 0; tbl[0].exp_res = 20'd70; tbl[0].exp_cyc = 7;
        tbl[1].n = 3; tbl[1].a = '{255, 255, 1, 0, 0, 0, 0, 0}; tbl[1].b = '{255, 1, 1, 0, 0, 0, 0, 0};
        tbl[1].gap = 2; tbl[1].exp_res = 20'd65281; tbl[1].exp_cyc = 10;
        tbl[2].n = 0; tbl[2].a = '{9, 9, 9, 9, 9, 9, 9, 9}; tbl[2].b = '{9, 9, 9, 9, 9, 9, 9, 9};
        tbl[2].gap = 0; tbl[2].exp_res = 20'd0; tbl[2].exp_cyc = 3;
        tbl[3].n = 1; tbl[3].a = '{255, 0, 0, 0, 0, 0, 0, 0}; tbl[3].b = '{255, 0, 0, 0, 0, 0, 0, 0};
        tbl[3].gap = 0; tbl[3].exp_res = 20'd65025; tbl[3].exp_cyc = 4;
        tbl[4].n = 8; tbl[4].a = '{255, 255, 255, 255, 255, 255, 255, 255};
        tbl[4].b = '{255, 255, 255, 255, 255, 255, 255, 255};
        tbl[4].gap = 1; tbl[4].exp_res = 20'd520200; tbl[4].exp_cyc = 18;

        rst = 1'b0; abort = 1'b0; start = 1'b0; len = '0; a_valid = 1'b0;
        a_data = '0; b_data = '0; res_ready = 1'b1;
        tick();
        tick();
        chk("reset outputs", {busy, a_ready, mac_en, mac_clr, res_valid}, 0);
        chk("reset res_data", res_data, 0);
        rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            job_check($sformatf("vec%0d", i), tbl[i].n, tbl[i].a, tbl[i].b, tbl[i].gap,
                      0, 1'b0, tbl[i].exp_res, tbl[i].exp_cyc);
        end

        // Result backpressure with start pulsed while DONE, including the handshake cycle
        job_check("backpressure", 2, '{10, 20, 0, 0, 0, 0, 0, 0}, '{3, 4, 0, 0, 0, 0, 0, 0},
                  0, 5, 1'b1, 20'd110, 5);
        tick();
        chk("start ignored stays idle", busy, 0);

        // Reset in the middle of RUN after two of four pairs
        start = 1'b1; len = LEN_W'(4); tick();
        start = 1'b0; a_valid = 1'b1; a_data = 8'd7; b_data = 8'd7; tick();
        tick();
        tick();
        chk("midrun a_ready", a_ready, 1);
        rst = 1'b0;
        tick();
        #1;
        chk("rst outputs", {busy, a_ready, mac_en, mac_clr, res_valid}, 0);
        chk("rst mac_in", {mac_in_1, mac_in_2}, 0);
        chk("rst res_data", res_data, 0);
        rst = 1'b1; a_valid = 1'b0;
        job_check("after_rst", 1, '{3, 0, 0, 0, 0, 0, 0, 0}, '{3, 0, 0, 0, 0, 0, 0, 0},
                  0, 0, 1'b0, 20'd9, 4);

`ifdef MAC_SEQ_ABORT_EN
        start = 1'b1; len = LEN_W'(3); tick();
        start = 1'b0; a_valid = 1'b1; a_data = 8'd4; b_data = 8'd4; tick();
        tick();
        abort = 1'b1;
        #1;
        chk("abort a_ready", a_ready, 0);
        chk("abort mac_en", mac_en, 0);
        tick();
        abort = 1'b0; a_valid = 1'b0;
        chk("abort idle", busy, 0);
        begin
            int rv = 0;
            for (int i = 0; i < 4; i++) begin
                if (res_valid) rv++;
                tick();
            end
            chk("abort no res_valid", rv, 0);
        end
        job_check("after_abort", 1, '{2, 0, 0, 0, 0, 0, 0, 0}, '{5, 0, 0, 0, 0, 0, 0, 0},
                  0, 0, 1'b0, 20'd10, 4);
`endif

        for (int j = 0; j < 20; j++) begin
            rn = int'($urandom_range(0, 8));
            rg = int'($urandom_range(0, 2));
            for (int k = 0; k < 8; k++) begin
                ra[k] = IN_W'($urandom);
                rb[k] = IN_W'($urandom);
            end
            job_check($sformatf("rand%0d", j), rn, ra, rb, rg, int'($urandom_range(0, 2)),
                      1'b0, dot(rn, ra, rb), lat(rn, rg));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
